sync_fifo_flex: RTL



---
 rtl/sync_fifo_flex_if.sv | 46 ++++
 rtl/sync_fifo_flex.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex_if.sv
// Handshake/status bundle between a sync_fifo_flex and its user; peak_level exists only with SYNC_FIFO_WATERMARK_EN.
// Master is the user side, slave is the FIFO side.
interface sync_fifo_flex_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] af_thresh;
  logic [CNT_W-1:0] ae_thresh;
  logic [CNT_W-1:0] data_avail;
  logic [CNT_W-1:0] room_avail;
  logic             overflow;
  logic             underflow;
  logic             err_clr;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CNT_W-1:0] peak_level;
`endif

  modport master (
    output clr, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           data_avail, room_avail, overflow, underflow
`ifdef SYNC_FIFO_WATERMARK_EN
    , input peak_level
`endif
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           data_avail, room_avail, overflow, underflow
`ifdef SYNC_FIFO_WATERMARK_EN
    , output peak_level
`endif
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of any DEPTH>=2; read data registered (1 cycle after pop), drops push-when-full / pop-when-empty
// and flags them sticky; synchronous flush; SYNC_FIFO_WATERMARK_EN adds a peak occupancy tracker.
module sync_fifo_flex #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            fifo_clk,
  input  logic            rst_n,
  sync_fifo_flex_if.slave bus
);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic [CNT_W-1:0] w_count_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_CNT);
  assign w_rd_ok   = bus.rd_en & ~w_empty;
  assign w_wr_ok   = bus.wr_en & (~w_full | w_rd_ok);
  assign w_ovf_evt = bus.wr_en & ~w_wr_ok;
  assign w_unf_evt = bus.rd_en & ~w_rd_ok;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is deliberately not reset.
  always_ff @(posedge fifo_clk) begin
    if (!bus.clr && w_wr_ok) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_ok) begin
        r_rd_ptr  <= ptr_inc(r_rd_ptr);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_rd_valid  <= w_rd_ok;
      r_count     <= w_count_nxt;
      // A fresh error in the same cycle as err_clr must survive.
      r_overflow  <= w_ovf_evt | (r_overflow & ~bus.err_clr);
      r_underflow <= w_unf_evt | (r_underflow & ~bus.err_clr);
    end
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CNT_W-1:0] r_peak;

  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (bus.clr) begin
      r_peak <= '0;
    end else if (bus.err_clr) begin
      r_peak <= w_count_nxt;
    end else if (w_count_nxt > r_peak) begin
      r_peak <= w_count_nxt;
    end
  end

  assign bus.peak_level = r_peak;
`endif

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= bus.af_thresh);
  assign bus.almost_empty = (r_count <= bus.ae_thresh);
  assign bus.data_avail   = r_count;
  assign bus.room_avail   = DEPTH_CNT - r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
